// File: rtl/node_pkt_injector.sv
// node_pkt_injector
// Node-side network interface feeding a switch local port (r/ack/data link).
// Parallel packets from the node are buffered in a small FIFO, then each one is
// sent after a request/ack handshake as a serial stream:
//   x[0], x[1], y[0], y[1], siz[0], siz[1], data[siz*8-1] .. data[0]
//
// Optional build macro: INJ_PARITY_EN
//   When defined, one even-parity bit (XOR of all preceding packet bits) is
//   appended after the last payload bit (after siz[1] for header-only packets).
//
// Ports:
//   clk       system clock, posedge
//   rst       synchronous active-high reset
//   in_valid  node offers a packet
//   in_ready  FIFO has room; push on in_valid && in_ready
//   in_x      destination x (2 bits)
//   in_y      destination y (2 bits)
//   in_siz    payload size in bytes, 0..3
//   in_data   payload, right aligned, bits above siz*8 ignored
//   req_out   request to switch
//   ack_in    grant from switch, sampled only while requesting
//   data_out  serial data to switch
//   busy      FSM not idle
//   pkt_done  one-cycle pulse after the last bit of a packet
module node_pkt_injector #(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned DW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_x,
  input  logic [1:0]    in_y,
  input  logic [1:0]    in_siz,
  input  logic [DW-1:0] in_data,
  output logic          req_out,
  input  logic          ack_in,
  output logic          data_out,
  output logic          busy,
  output logic          pkt_done
);

  localparam int unsigned AW  = $clog2(QDEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BCW = 5;

  typedef struct packed {
    logic [1:0]    x;
    logic [1:0]    y;
    logic [1:0]    siz;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HDR,
    S_DATA,
    S_PAR,
    S_END
  } state_t;

  // State entered after the final header/payload bit.
`ifdef INJ_PARITY_EN
  localparam state_t S_TAIL = S_PAR;
`else
  localparam state_t S_TAIL = S_END;
`endif

  // ---------------------------------------------------------------------------
  // Packet FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          push;
  logic          pop;
  entry_t        in_entry;
  entry_t        head;

  assign in_entry = '{x: in_x, y: in_y, siz: in_siz, data: in_data};
  assign head     = mem_q[rd_ptr_q];
  assign push     = in_valid && in_ready_q;

  // Entry storage; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Pointer and occupancy next-state; ready tracks the next occupancy so
  // in_ready always equals (count != QDEPTH) for the current cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CW'(QDEPTH));
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  entry_t         wk_q, wk_d;
  logic           req_q, req_d;
  logic           data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [5:0]     hdr_d;
  logic           par_bit;

`ifdef INJ_PARITY_EN
  logic [DW-1:0] pay_mask;

  // Even parity over the header and the live payload bytes of the working entry.
  always_comb begin
    pay_mask = (DW'(1) << {wk_q.siz, 3'b000}) - DW'(1);
    par_bit  = (^{wk_q.siz, wk_q.y, wk_q.x}) ^ (^(wk_q.data & pay_mask));
  end
`else
  assign par_bit = 1'b0;
`endif

  // Next-state logic; header counts up 0..5, payload counts down siz*8-1..0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wk_d    = wk_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_in) begin
          state_d = S_HDR;
          cnt_d   = '0;
          wk_d    = head;
        end
      end
      S_HDR: begin
        if (cnt_q == BCW'(5)) begin
          if (wk_q.siz != 2'd0) begin
            state_d = S_DATA;
            cnt_d   = BCW'({wk_q.siz, 3'b000}) - BCW'(1);
          end else begin
            state_d = S_TAIL;
          end
        end else begin
          cnt_d = cnt_q + BCW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          state_d = S_TAIL;
        end else begin
          cnt_d = cnt_q - BCW'(1);
        end
      end
      S_PAR: begin
        state_d = S_END;
      end
      S_END: begin
        pop     = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-values decoded from the next state so every output is a flop
  // whose value lines up with the state it belongs to.
  always_comb begin
    req_d  = 1'b0;
    data_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_END);
    hdr_d  = {wk_d.siz, wk_d.y, wk_d.x};
    case (state_d)
      S_REQ: begin
        req_d = 1'b1;
      end
      S_HDR: begin
        req_d  = 1'b1;
        data_d = hdr_d[cnt_d[2:0]];
      end
      S_DATA: begin
        req_d  = 1'b1;
        data_d = wk_d.data[cnt_d];
      end
      S_PAR: begin
        req_d  = 1'b1;
        data_d = par_bit;
      end
      default: begin
        req_d  = 1'b0;
        data_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wk_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      req_q      <= 1'b0;
      data_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wk_q       <= wk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      req_q      <= req_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign req_out  = req_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;

endmodule

// File: tb/tb_node_pkt_injector.sv
// Testbench for node_pkt_injector: scoreboard of expected serial streams,
// filled on every push and consumed by a monitor watching the switch link.
module tb_node_pkt_injector;

`ifdef INJ_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_x;
  logic [1:0]  in_y;
  logic [1:0]  in_siz;
  logic [23:0] in_data;
  logic        req_out;
  logic        ack_in;
  logic        data_out;
  logic        busy;
  logic        pkt_done;

  typedef struct {
    logic [31:0] bits;
    int          len;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          pkts_seen = 0;
  logic [31:0] last_obs = '0;
  int          last_len = 0;

  node_pkt_injector #(.QDEPTH(2), .DW(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_siz   (in_siz),
    .in_data  (in_data),
    .req_out  (req_out),
    .ack_in   (ack_in),
    .data_out (data_out),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  // Reference serial stream for one packet, bit 0 sent first.
  function automatic exp_t make_stream(input logic [1:0] x, input logic [1:0] y,
                                       input logic [1:0] siz, input logic [23:0] d);
    exp_t e;
    e.bits    = '0;
    e.bits[0] = x[0];
    e.bits[1] = x[1];
    e.bits[2] = y[0];
    e.bits[3] = y[1];
    e.bits[4] = siz[0];
    e.bits[5] = siz[1];
    e.len     = 6;
    for (int i = int'(siz) * 8 - 1; i >= 0; i--) begin
      e.bits[e.len] = d[i];
      e.len++;
    end
`ifdef INJ_PARITY_EN
    e.bits[e.len] = ^e.bits;
    e.len++;
`endif
    return e;
  endfunction

  // Offer one packet, waiting (bounded) for room; records the expected stream.
  task automatic push(input logic [1:0] x, input logic [1:0] y, input logic [1:0] siz,
                      input logic [23:0] d, output bit ok);
    int n = 0;
    while (in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      in_x     = x;
      in_y     = y;
      in_siz   = siz;
      in_data  = d;
      in_valid = 1'b1;
      sb.push_back(make_stream(x, y, siz, d));
      @(posedge clk); #2;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    int n = 0;
    while (pkts_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (pkts_seen >= target);
  endtask

  // Link monitor: detects the grant, compares each serial bit with the
  // scoreboard, checks the END cycle and the request gap between packets.
  task automatic monitor();
    exp_t        cur;
    int          idx = 0;
    bit          active = 0;
    bit          starting = 0;
    bit          done_next = 0;
    bit          tx_now;
    bit          prev_req = 0;
    bit          seen_req = 0;
    int          low_run = 0;
    logic [31:0] obs = '0;
    cur.bits = '0;
    cur.len  = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        active = 0; starting = 0; done_next = 0;
        prev_req = 0; seen_req = 0; low_run = 0;
        continue;
      end
      tx_now = 0;
      n_total++;
      if (done_next) begin
        if (pkt_done !== 1'b1 || req_out !== 1'b0 || data_out !== 1'b0)
          $display("FAIL end_cycle: pkt_done=%b req_out=%b data_out=%b, required 1/0/0",
                   pkt_done, req_out, data_out);
        else n_pass++;
        last_obs  = obs;
        last_len  = cur.len;
        pkts_seen++;
        done_next = 0;
      end else begin
        if (pkt_done !== 1'b0) $display("FAIL stray_done: pkt_done=%b, required 0", pkt_done);
        else n_pass++;
      end
      if (starting) begin
        starting = 0;
        n_total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_empty: transmission started with no packet queued, required none");
        end else begin
          n_pass++;
          cur    = sb.pop_front();
          active = 1;
          idx    = 0;
          obs    = '0;
        end
      end
      if (active) begin
        tx_now = 1;
        n_total++;
        if (data_out !== cur.bits[idx] || req_out !== 1'b1)
          $display("FAIL tx_bit[%0d]: data_out=%b req_out=%b, required %b/1",
                   idx, data_out, req_out, cur.bits[idx]);
        else n_pass++;
        obs[idx] = data_out;
        idx++;
        if (idx == cur.len) begin
          active    = 0;
          done_next = 1;
        end
      end else begin
        n_total++;
        if (data_out !== 1'b0) $display("FAIL idle_data: data_out=%b, required 0", data_out);
        else n_pass++;
      end
      if (!tx_now && req_out === 1'b1 && ack_in === 1'b1) starting = 1;
      if (req_out === 1'b1) begin
        if (!prev_req && seen_req) begin
          n_total++;
          if (low_run < 2) $display("FAIL req_gap: low cycles=%0d, required >=2", low_run);
          else n_pass++;
        end
        seen_req = 1;
        low_run  = 0;
      end else begin
        low_run++;
      end
      prev_req = req_out;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || req_out !== 1'b0 || data_out !== 1'b0 ||
        busy !== 1'b0 || pkt_done !== 1'b0)
      $display("FAIL reset_values: in_ready=%b req=%b data=%b busy=%b done=%b, required 1/0/0/0/0",
               in_ready, req_out, data_out, busy, pkt_done);
    else n_pass++;
  endtask

  task automatic test_basic_latency();
    bit ok;
    int base = pkts_seen;
    ack_in = 1'b1;
    @(posedge clk); #2;
    push(2'd2, 2'd1, 2'd1, 24'h0000A5, ok);
    n_total++;
    if (!ok) $display("FAIL basic_push: accepted=%b, required 1", ok); else n_pass++;
    @(negedge clk);
    n_total++;
    if (req_out !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_lat1: req=%b busy=%b, required 0/0", req_out, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (req_out !== 1'b1 || busy !== 1'b1 || data_out !== 1'b0)
      $display("FAIL basic_lat2: req=%b busy=%b data=%b, required 1/1/0", req_out, busy, data_out);
    else n_pass++;
    wait_pkts(base + 1, 100, ok);
    n_total++;
    if (!ok) $display("FAIL basic_timeout: pkts=%0d, required %0d", pkts_seen, base + 1);
    else n_pass++;
    n_total++;
    if (last_len !== 14 + PB || last_obs[13:0] !== 14'b10100101010110)
      $display("FAIL basic_stream: len=%0d bits=%b, required %0d/10100101010110",
               last_len, last_obs[13:0], 14 + PB);
    else n_pass++;
  endtask

  task automatic test_header_only();
    bit ok;
    int base = pkts_seen;
    ack_in = 1'b1;
    push(2'd3, 2'd3, 2'd0, 24'hFFFFFF, ok);
    wait_pkts(base + 1, 100, ok);
    n_total++;
    if (!ok) $display("FAIL hdr_timeout: pkts=%0d, required %0d", pkts_seen, base + 1);
    else n_pass++;
    n_total++;
    if (last_len !== 6 + PB || last_obs[5:0] !== 6'b001111)
      $display("FAIL hdr_stream: len=%0d bits=%b, required %0d/001111",
               last_len, last_obs[5:0], 6 + PB);
    else n_pass++;
  endtask

  task automatic test_ignored_bits();
    bit          ok;
    logic [15:0] pay;
    int          base = pkts_seen;
    ack_in = 1'b1;
    push(2'd0, 2'd1, 2'd2, 24'hAB1234, ok);
    wait_pkts(base + 1, 100, ok);
    for (int i = 0; i < 16; i++) pay[15 - i] = last_obs[6 + i];
    n_total++;
    if (!ok || last_len !== 22 + PB || pay !== 16'h1234)
      $display("FAIL upper_ignored: done=%b len=%0d payload=%h, required 1/%0d/1234",
               ok, last_len, pay, 22 + PB);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok_a, ok_b, ok_c, ok;
    int base = pkts_seen;
    ack_in = 1'b0;
    push(2'd1, 2'd0, 2'd1, 24'h00003C, ok_a);
    push(2'd0, 2'd2, 2'd2, 24'h00F00D, ok_b);
    n_total++;
    if (!ok_a || !ok_b || in_ready !== 1'b0)
      $display("FAIL b2b_full: pushes=%b%b in_ready=%b, required 11/0", ok_a, ok_b, in_ready);
    else n_pass++;
    repeat (5) begin
      @(negedge clk);
      n_total++;
      if (in_ready !== 1'b0 || req_out !== 1'b1)
        $display("FAIL b2b_hold: in_ready=%b req=%b, required 0/1", in_ready, req_out);
      else n_pass++;
    end
    fork
      begin
        repeat (3) @(posedge clk);
        #2 ack_in = 1'b1;
      end
      push(2'd3, 2'd1, 2'd0, 24'h000000, ok_c);
    join
    n_total++;
    if (!ok_c || pkts_seen - base !== 1)
      $display("FAIL b2b_third: accepted=%b done_before=%0d, required 1/1", ok_c, pkts_seen - base);
    else n_pass++;
    wait_pkts(base + 3, 300, ok);
    n_total++;
    if (!ok) $display("FAIL b2b_timeout: pkts=%0d, required %0d", pkts_seen, base + 3);
    else n_pass++;
  endtask

  task automatic test_delayed_ack();
    bit          ok;
    logic [23:0] pay;
    int          base = pkts_seen;
    ack_in = 1'b0;
    push(2'd1, 2'd2, 2'd3, 24'hC3F00F, ok);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (req_out !== 1'b1 || data_out !== 1'b0)
      $display("FAIL dly_req: req=%b data=%b, required 1/0", req_out, data_out);
    else n_pass++;
    repeat (10) @(posedge clk);
    #2 ack_in = 1'b1;
    wait_pkts(base + 1, 200, ok);
    for (int i = 0; i < 24; i++) pay[23 - i] = last_obs[6 + i];
    n_total++;
    if (!ok || last_len !== 30 + PB || pay !== 24'hC3F00F)
      $display("FAIL dly_stream: done=%b len=%0d payload=%h, required 1/%0d/c3f00f",
               ok, last_len, pay, 30 + PB);
    else n_pass++;
    push(2'd2, 2'd2, 2'd1, 24'h000081, ok);
    wait_pkts(base + 2, 100, ok);
    n_total++;
    if (!ok) $display("FAIL dly_next: pkts=%0d, required %0d", pkts_seen, base + 2);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok_a, ok_b;
    ack_in = 1'b1;
    @(posedge clk); #2;
    push(2'd1, 2'd1, 2'd2, 24'h005A5A, ok_a);
    push(2'd2, 2'd3, 2'd1, 24'h000077, ok_b);
    repeat (17) @(posedge clk);
    #2;
    n_total++;
    if (!ok_a || !ok_b || req_out !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_pre: pushes=%b%b req=%b busy=%b, required 11/1/1", ok_a, ok_b, req_out, busy);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_total++;
    if (req_out !== 1'b0 || data_out !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_abort: req=%b data=%b in_ready=%b busy=%b, required 0/0/1/0",
               req_out, data_out, in_ready, busy);
    else n_pass++;
    repeat (6) begin
      @(negedge clk);
      n_total++;
      if (req_out !== 1'b0 || busy !== 1'b0)
        $display("FAIL rst_empty: req=%b busy=%b, required 0/0", req_out, busy);
      else n_pass++;
    end
  endtask

  task automatic test_tail_bit();
    bit   ok;
    logic lb;
    int   base = pkts_seen;
    ack_in = 1'b1;
    push(2'd1, 2'd0, 2'd1, 24'h000001, ok);
    wait_pkts(base + 1, 100, ok);
    lb = last_obs[last_len - 1];
    n_total++;
    if (!ok || last_len !== 14 + PB || lb !== 1'b1 || last_obs[13:0] !== 14'b10000000010001)
      $display("FAIL tail_bit: done=%b len=%0d last=%b bits=%b, required 1/%0d/1/10000000010001",
               ok, last_len, lb, last_obs[13:0], 14 + PB);
    else n_pass++;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_siz   = '0;
    in_data  = '0;
    ack_in   = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    test_reset();
    test_basic_latency();
    test_header_only();
    test_ignored_bits();
    test_back_to_back();
    test_delayed_ack();
    test_mid_reset();
    test_tail_bit();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
